// File: rtl/mge_phy_reconfig_sequencer.sv
// mge_phy_reconfig_sequencer: walks a table of DPRIO read-modify-write
// entries and applies each one over an Avalon-MM reconfig port.
// Ports:
//   clk, reset        sole clock, synchronous active-high reset
//   start             one-cycle pulse, accepted only when idle
//   busy, done        run in progress / one-cycle end-of-sequence pulse
//   error             sticky timeout flag, cleared by reset or accepted start
//   rom_index         entry index into the external table
//   rom_data          table word: [25:16] address, [15:8] mask, [7:0] value
//   avmm_*            Avalon-MM master (address, read, write, writedata,
//                     readdata, waitrequest)
module mge_phy_reconfig_sequencer #(
   parameter int RAM_DEPTH = 7,
   parameter int IDX_W     = 3,
   parameter int TIMEOUT   = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] rom_index,
   input  logic [25:0]      rom_data,
   output logic [9:0]       avmm_address,
   output logic             avmm_read,
   output logic             avmm_write,
   output logic [31:0]      avmm_writedata,
   input  logic [31:0]      avmm_readdata,
   input  logic             avmm_waitrequest
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RAM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MOD,
      S_WR,
      S_NEXT,
      S_FIN
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_wait;
   logic [31:0]      r_rdq;
   logic [31:0]      r_wdata;
   logic [9:0]       r_addr;
   logic [7:0]       w_new8;
   logic             w_strobe;
   logic             w_stall;

   assign w_new8   = (r_rdq[7:0] & ~rom_data[15:8])
                   | (rom_data[7:0] & rom_data[15:8]);
   assign w_strobe = avmm_read | avmm_write;
   assign w_stall  = w_strobe & avmm_waitrequest;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = r_state;
      busy           = 1'b0;
      done           = 1'b0;
      avmm_read      = 1'b0;
      avmm_write     = 1'b0;
      avmm_address   = '0;
      avmm_writedata = '0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_RD;
            end
         end
         S_RD: begin
            busy         = 1'b1;
            avmm_read    = 1'b1;
            avmm_address = rom_data[25:16];
            if (!avmm_waitrequest) begin
               w_next = S_MOD;
            end else if (r_wait == LAST_WAIT) begin
               w_next = S_FIN;
            end
         end
         S_MOD: begin
            busy = 1'b1;
            // unchanged byte: skip the write cycle entirely
            if (w_new8 == r_rdq[7:0]) begin
               w_next = S_NEXT;
            end else begin
               w_next = S_WR;
            end
         end
         S_WR: begin
            busy           = 1'b1;
            avmm_write     = 1'b1;
            avmm_address   = r_addr;
            avmm_writedata = r_wdata;
            if (!avmm_waitrequest) begin
               w_next = S_NEXT;
            end else if (r_wait == LAST_WAIT) begin
               w_next = S_FIN;
            end
         end
         S_NEXT: begin
            busy = 1'b1;
            if (rom_index == LAST_IDX) begin
               w_next = S_FIN;
            end else begin
               w_next = S_RD;
            end
         end
         S_FIN: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rom_index <= '0;
         error     <= 1'b0;
         r_wait    <= '0;
         r_rdq     <= '0;
         r_wdata   <= '0;
         r_addr    <= '0;
      end else begin
         if (r_state == S_IDLE && start) begin
            error     <= 1'b0;
            rom_index <= '0;
         end
         if (r_state == S_NEXT && rom_index != LAST_IDX) begin
            rom_index <= rom_index + IDX_W'(1);
         end
         // address is latched so the write targets what was read
         if (r_state == S_RD) begin
            r_addr <= rom_data[25:16];
         end
         if (avmm_read && !avmm_waitrequest) begin
            r_rdq <= avmm_readdata;
         end
         if (r_state == S_MOD) begin
            r_wdata <= {r_rdq[31:8], w_new8};
         end
         // counter restarts whenever no stalled transfer is in flight
         if (w_stall) begin
            r_wait <= r_wait + CNT_W'(1);
            if (r_wait == LAST_WAIT) begin
               error <= 1'b1;
            end
         end else begin
            r_wait <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mge_phy_reconfig_sequencer.sv
// Testbench for mge_phy_reconfig_sequencer: table/memory model,
// per-cycle bus compare and directed scenarios.
module tb_mge_phy_reconfig_sequencer;

   localparam int DEPTH = 7;
   localparam int IW    = 3;
   localparam int TMO   = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, error;
   logic [IW-1:0] rom_index;
   logic [25:0]   rom_data;
   logic [9:0]    avmm_address;
   logic          avmm_read, avmm_write;
   logic [31:0]   avmm_writedata, avmm_readdata;
   logic          avmm_waitrequest;

   logic [25:0]   rom [0:7];
   logic [31:0]   mem [0:1023];
   logic [31:0]   mm  [0:1023];
   int            stall_n = 0;
   int            stall_cnt = 0;
   bit            stuck = 1'b0;

   typedef struct {
      bit          w;
      logic [9:0]  a;
      logic [31:0] d;
   } xfer_t;

   typedef struct {
      bit          w;
      logic [9:0]  a;
      logic [31:0] d;
      int          len;
   } obs_t;

   xfer_t exp_q[$];
   obs_t  obs_q[$];
   int    exp_done, done_at, cyc, strobe_cyc, cur_len;
   bit    exp_err, armed, active, quiet;
   bit    prev_stall, prev_r, prev_w;
   logic [9:0]  prev_a;
   logic [31:0] prev_d;
   int    checks = 0;
   int    passed = 0;

   always #5 clk = ~clk;

   mge_phy_reconfig_sequencer #(
      .RAM_DEPTH(DEPTH),
      .IDX_W(IW),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .busy(busy),
      .done(done),
      .error(error),
      .rom_index(rom_index),
      .rom_data(rom_data),
      .avmm_address(avmm_address),
      .avmm_read(avmm_read),
      .avmm_write(avmm_write),
      .avmm_writedata(avmm_writedata),
      .avmm_readdata(avmm_readdata),
      .avmm_waitrequest(avmm_waitrequest)
   );

   assign rom_data = rom[rom_index];
   assign avmm_waitrequest = (avmm_read | avmm_write)
                           && (stuck || stall_cnt < stall_n);
   // garbage while stalled, so a premature capture shows up
   assign avmm_readdata = avmm_waitrequest ? 32'hDEADBEEF
                                           : mem[avmm_address];

   always @(posedge clk) begin
      if (reset) begin
         stall_cnt <= 0;
      end else if (avmm_read | avmm_write) begin
         if (avmm_waitrequest) begin
            stall_cnt <= stall_cnt + 1;
         end else begin
            stall_cnt <= 0;
            if (avmm_write) mem[avmm_address] = avmm_writedata;
         end
      end else begin
         stall_cnt <= 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Expected transfers derived from the table and a copy of memory.
   task automatic build_model(input int stall, input bit tmo);
      logic [9:0]  a;
      logic [31:0] old;
      logic [7:0]  mk, vl, n8;
      int          c;
      exp_q.delete();
      if (tmo) begin
         exp_done = 1 + TMO;
         exp_err  = 1'b1;
         return;
      end
      mm = mem;
      c  = 1;
      for (int i = 0; i < DEPTH; i++) begin
         a   = rom[i][25:16];
         mk  = rom[i][15:8];
         vl  = rom[i][7:0];
         old = mm[a];
         exp_q.push_back('{w: 1'b0, a: a, d: old});
         c += 2 + stall;
         n8 = (old[7:0] & ~mk) | (vl & mk);
         if (n8 != old[7:0]) begin
            exp_q.push_back('{w: 1'b1, a: a, d: {old[31:8], n8}});
            mm[a] = {old[31:8], n8};
            c += 1 + stall;
         end
         c += 1;
      end
      exp_done = c;
      exp_err  = 1'b0;
   endtask

   always @(negedge clk) begin
      xfer_t e;
      if (!reset) begin
         chk("strobe_excl", 32'(avmm_read & avmm_write), 32'd0);
         if (armed && start) begin
            armed      = 1'b0;
            active     = 1'b1;
            cyc        = 0;
            strobe_cyc = 0;
            cur_len    = 0;
            prev_stall = 1'b0;
            obs_q.delete();
         end else if (active) begin
            cyc++;
         end
         if (active) begin
            if (cyc == 0) begin
               chk("busy_c0", 32'(busy), 32'd0);
            end else begin
               if (avmm_read | avmm_write) begin
                  strobe_cyc++;
                  cur_len++;
               end
               if (prev_stall && !done) begin
                  chk("hold_rd", 32'(avmm_read), 32'(prev_r));
                  chk("hold_wr", 32'(avmm_write), 32'(prev_w));
                  chk("hold_addr", 32'(avmm_address), 32'(prev_a));
                  chk("hold_wdata", avmm_writedata, prev_d);
               end
               if ((avmm_read | avmm_write) && !avmm_waitrequest) begin
                  obs_q.push_back('{w: avmm_write, a: avmm_address,
                     d: avmm_write ? avmm_writedata : avmm_readdata,
                     len: cur_len});
                  cur_len = 0;
                  if (exp_q.size() == 0) begin
                     chk("extra_xfer", 32'd1, 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("xfer_kind", 32'(avmm_write), 32'(e.w));
                     chk("xfer_addr", 32'(avmm_address), 32'(e.a));
                     if (e.w) chk("xfer_wdata", avmm_writedata, e.d);
                  end
               end
               prev_stall = (avmm_read | avmm_write) && avmm_waitrequest;
               prev_r = avmm_read;
               prev_w = avmm_write;
               prev_a = avmm_address;
               prev_d = avmm_writedata;
               if (done) begin
                  done_at = cyc;
                  chk("done_cyc", 32'(cyc), 32'(exp_done));
                  chk("err_at_done", 32'(error), 32'(exp_err));
                  chk("busy_at_done", 32'(busy), 32'd0);
                  chk("missing_xfers", 32'(exp_q.size()), 32'd0);
                  active = 1'b0;
               end else begin
                  chk("busy_run", 32'(busy), 32'd1);
                  chk("err_run", 32'(error), 32'd0);
                  if (cyc > exp_done) begin
                     chk("no_done", 32'(cyc), 32'(exp_done));
                     active = 1'b0;
                  end
               end
            end
         end else if (!quiet) begin
            chk("idle_strobes", 32'({avmm_read, avmm_write}), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_strobes"}, 32'({avmm_read, avmm_write}), 32'd0);
      chk({tag, "_addr"}, 32'(avmm_address), 32'd0);
      chk({tag, "_wdata"}, avmm_writedata, 32'd0);
      chk({tag, "_index"}, 32'(rom_index), 32'd0);
   endtask

   task automatic kick();
      @(posedge clk);
      #1;
      start = 1'b1;
      armed = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 400 && active; k++) @(posedge clk);
      if (active) begin
         chk("run_bound", 32'd1, 32'd0);
         active = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[10'h132] = 32'h0000_00F0;
      mem[10'h13B] = 32'h1234_5600;
      mem[10'h139] = 32'h0000_0009;
      rom[0] = 26'h132_0404;
      rom[1] = 26'h13B_FF19;
      rom[2] = 26'h139_0701;
      rom[3] = 26'h050_0F0A;
      rom[4] = 26'h132_0FF0;
      rom[5] = 26'h3FF_FF55;
      rom[6] = 26'h000_0000;
      rom[7] = 26'h000_0000;
      armed  = 1'b0;
      active = 1'b0;
      quiet  = 1'b0;
      done_at = 0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      reset = 1'b0;

      // zero wait states
      stall_n = 0;
      build_model(0, 1'b0);
      kick();
      wait_idle();
      chk("A_done_at", 32'(done_at), 32'd27);
      chk("A_nxfers", 32'(obs_q.size()), 32'd12);
      if (obs_q.size() >= 6) begin
         chk("A_rd0_addr", 32'(obs_q[0].a), 32'h132);
         chk("A_wr0_kind", 32'(obs_q[1].w), 32'd1);
         chk("A_wr0_addr", 32'(obs_q[1].a), 32'h132);
         chk("A_wr0_data", obs_q[1].d, 32'h0000_00F4);
         chk("A_wr1_data", obs_q[3].d, 32'h1234_5619);
         chk("A_skip_kind", 32'(obs_q[5].w), 32'd0);
         chk("A_skip_addr", 32'(obs_q[5].a), 32'h050);
      end
      chk("A_error", 32'(error), 32'd0);

      // three wait states on every transfer
      stall_n = 3;
      build_model(3, 1'b0);
      kick();
      wait_idle();
      chk("B_done_at", 32'(done_at), 32'd51);
      if (obs_q.size() >= 1) chk("B_rd_hold", 32'(obs_q[0].len), 32'd4);
      stall_n = 0;

      // stuck waitrequest
      stuck = 1'b1;
      build_model(0, 1'b1);
      kick();
      wait_idle();
      stuck = 1'b0;
      chk("C_done_at", 32'(done_at), 32'd16);
      chk("C_strobe_cyc", 32'(strobe_cyc), 32'd15);
      chk("C_nxfers", 32'(obs_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("C_err_sticky", 32'(error), 32'd1);

      // next start clears error
      build_model(0, 1'b0);
      kick();
      wait_idle();
      chk("D_error", 32'(error), 32'd0);

      // start while busy is ignored
      mem[10'h132] = 32'hAB00_0011;
      build_model(0, 1'b0);
      kick();
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      // reset in the middle of a write
      mem[10'h132] = 32'h0000_00F0;
      build_model(0, 1'b0);
      kick();
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (avmm_write) break;
      end
      chk("F_saw_write", 32'(avmm_write), 32'd1);
      quiet  = 1'b1;
      active = 1'b0;
      reset  = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("mid");
      reset = 1'b0;
      quiet = 1'b0;

      // clean run after the abort
      build_model(0, 1'b0);
      kick();
      wait_idle();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
